// File: rtl/fifo_v4.sv
// Synchronous FIFO with valid/ready handshakes, optional fall-through bypass,
// programmable almost-full/almost-empty flags, occupancy and peak watermark.
module fifo_v4 #(
    parameter int FALL_THROUGH = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int PTR_W        = $clog2(DEPTH),
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic [CNT_W-1:0]      afull_thr_i,
    input  logic [CNT_W-1:0]      aempty_thr_i,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      peak_o,
    input  logic                  clear_peak_i
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_wptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_peak;

    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_rd;
    logic [CNT_W-1:0]      w_countNext;
    logic [CNT_W-1:0]      w_peakNext;

    // Pointers wrap explicitly so any DEPTH works, not only powers of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_bypass    = (FALL_THROUGH != 0) && (r_count == '0);
    assign in_ready_o  = (r_count != FULL_CNT);
    assign out_valid_o = w_bypass ? in_valid_i : (r_count != '0);
    assign out_data_o  = w_bypass ? in_data_i : r_mem[r_rptr];

    assign w_push = in_valid_i && in_ready_o;
    assign w_pop  = out_valid_o && out_ready_i;
    // A bypassed beat that is consumed immediately never touches storage.
    assign w_wr   = w_push && !(w_bypass && out_ready_i);
    assign w_rd   = w_pop && !w_bypass;

    assign usage_o        = r_count;
    assign peak_o         = r_peak;
    assign almost_full_o  = (r_count >= afull_thr_i);
    assign almost_empty_o = (r_count <= aempty_thr_i);

    always_comb begin
        w_countNext = r_count;
        if (flush_i) begin
            w_countNext = '0;
        end else if (w_wr && !w_rd) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (w_rd && !w_wr) begin
            w_countNext = r_count - CNT_W'(1);
        end

        w_peakNext = r_peak;
        if (clear_peak_i) begin
            w_peakNext = w_countNext;
        end else if (w_countNext > r_peak) begin
            w_peakNext = w_countNext;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_peak  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_countNext;
            r_peak  <= w_peakNext;
            if (flush_i) begin
                r_rptr <= '0;
                r_wptr <= '0;
            end else begin
                if (w_wr) begin
                    r_mem[r_wptr] <= in_data_i;
                    r_wptr        <= nextPtr(r_wptr);
                end
                if (w_rd) begin
                    r_rptr <= nextPtr(r_rptr);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_v4.sv
// Self-checking bench for fifo_v4: two instances (DEPTH=4 registered, DEPTH=5
// fall-through) share one stimulus stream and are each tracked by a list model.
module tb_fifo_v4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       inValid = 1'b0;
    logic [7:0] inData = 8'h00;
    logic       outReady = 1'b0;
    logic [2:0] afThr = 3'd3;
    logic [2:0] aeThr = 3'd1;
    logic       clearPeak = 1'b0;

    logic       aInReady, aOutValid, aAf, aAe;
    logic [7:0] aOutData;
    logic [2:0] aUsage, aPeak;
    logic       bInReady, bOutValid, bAf, bAe;
    logic [7:0] bOutData;
    logic [2:0] bUsage, bPeak;

    int checks = 0;
    int errors = 0;

    // Model: each FIFO is an ordered list, head at index 0.
    int mData [2][16];
    int mCount [2];
    int mPeak [2];
    int mDepth [2] = '{4, 5};
    int mFt [2] = '{0, 1};

    always #5 clk = ~clk;

    fifo_v4 #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(4)) uA (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(aInReady), .in_data_i(inData),
        .out_valid_o(aOutValid), .out_ready_i(outReady), .out_data_o(aOutData),
        .afull_thr_i(afThr), .aempty_thr_i(aeThr), .usage_o(aUsage),
        .almost_full_o(aAf), .almost_empty_o(aAe), .peak_o(aPeak),
        .clear_peak_i(clearPeak)
    );

    fifo_v4 #(.FALL_THROUGH(1), .DATA_WIDTH(8), .DEPTH(5)) uB (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(bInReady), .in_data_i(inData),
        .out_valid_o(bOutValid), .out_ready_i(outReady), .out_data_o(bOutData),
        .afull_thr_i(afThr), .aempty_thr_i(aeThr), .usage_o(bUsage),
        .almost_full_o(bAf), .almost_empty_o(bAe), .peak_o(bPeak),
        .clear_peak_i(clearPeak)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       expIr;
        logic       expOv;
        logic [7:0] expData;
        int         expUsage;
        int         expPeak;
        logic       expAf;
        logic       expAe;
    } vec_t;

    vec_t vecs [15];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expBypass(input int k);
        return (mFt[k] != 0 && mCount[k] == 0) ? 1 : 0;
    endfunction

    function automatic int expReady(input int k);
        return (mCount[k] != mDepth[k]) ? 1 : 0;
    endfunction

    function automatic int expValid(input int k);
        if (expBypass(k) != 0) return int'(inValid);
        return (mCount[k] != 0) ? 1 : 0;
    endfunction

    function automatic int expData(input int k);
        if (expBypass(k) != 0) return int'(inData);
        return mData[k][0];
    endfunction

    task automatic resetModels();
        for (int k = 0; k < 2; k++) begin
            mCount[k] = 0;
            mPeak[k]  = 0;
        end
    endtask

    task automatic modelStep(input int k);
        int push;
        int pop;
        push = (inValid && expReady(k) != 0) ? 1 : 0;
        pop  = (expValid(k) != 0 && outReady) ? 1 : 0;
        if (flush) begin
            mCount[k] = 0;
        end else if (!(expBypass(k) != 0 && push != 0 && outReady)) begin
            if (pop != 0) begin
                for (int i = 0; i < 15; i++) mData[k][i] = mData[k][i+1];
                mCount[k]--;
            end
            if (push != 0) begin
                mData[k][mCount[k]] = int'(inData);
                mCount[k]++;
            end
        end
        if (clearPeak) mPeak[k] = mCount[k];
        else if (mCount[k] > mPeak[k]) mPeak[k] = mCount[k];
    endtask

    task automatic checkModel();
        checkOutput("A in_ready", int'(aInReady), expReady(0));
        checkOutput("A out_valid", int'(aOutValid), expValid(0));
        if (expValid(0) != 0) checkOutput("A out_data", int'(aOutData), expData(0));
        checkOutput("A usage", int'(aUsage), mCount[0]);
        checkOutput("A peak", int'(aPeak), mPeak[0]);
        checkOutput("A almost_full", int'(aAf), (mCount[0] >= int'(afThr)) ? 1 : 0);
        checkOutput("A almost_empty", int'(aAe), (mCount[0] <= int'(aeThr)) ? 1 : 0);
        checkOutput("B in_ready", int'(bInReady), expReady(1));
        checkOutput("B out_valid", int'(bOutValid), expValid(1));
        if (expValid(1) != 0) checkOutput("B out_data", int'(bOutData), expData(1));
        checkOutput("B usage", int'(bUsage), mCount[1]);
        checkOutput("B peak", int'(bPeak), mPeak[1]);
        checkOutput("B almost_full", int'(bAf), (mCount[1] >= int'(afThr)) ? 1 : 0);
        checkOutput("B almost_empty", int'(bAe), (mCount[1] <= int'(aeThr)) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic f, input logic iv, input logic [7:0] d,
                                 input logic ordy, input logic cp);
        flush     = f;
        inValid   = iv;
        inData    = d;
        outReady  = ordy;
        clearPeak = cp;
    endtask

    task automatic toNegedge();
        @(negedge clk);
        checkModel();
    endtask

    task automatic toPosedge();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    task automatic step();
        toNegedge();
        toPosedge();
    endtask

    // Reset is raised and released between clock edges.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        resetModels();
        #1;
        toNegedge();
        #1;
        rst = 1'b0;
        toPosedge();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3, 3, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 4, 4, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3, 4, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2, 4, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1, 4, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 4, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 1, 4, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 2, 4, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA0, 3, 4, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 8'hA0, 4, 4, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hA1, 3, 4, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 4, 4, 1'b1, 1'b0};

        resetModels();
        #2;
        doReset();

        $display("[TB] fill, drain, full-with-pop and thresholds on DEPTH=4");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
            toNegedge();
            checkOutput($sformatf("vec%0d in_ready", i), int'(aInReady), int'(vecs[i].expIr));
            checkOutput($sformatf("vec%0d out_valid", i), int'(aOutValid), int'(vecs[i].expOv));
            if (vecs[i].expOv)
                checkOutput($sformatf("vec%0d out_data", i), int'(aOutData), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d usage", i), int'(aUsage), vecs[i].expUsage);
            checkOutput($sformatf("vec%0d peak", i), int'(aPeak), vecs[i].expPeak);
            checkOutput($sformatf("vec%0d almost_full", i), int'(aAf), int'(vecs[i].expAf));
            checkOutput($sformatf("vec%0d almost_empty", i), int'(aAe), int'(vecs[i].expAe));
            toPosedge();
        end

        $display("[TB] async reset mid-cycle at usage 4");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst in_ready", int'(aInReady), 1);
        checkOutput("rst out_valid", int'(aOutValid), 0);
        checkOutput("rst out_data", int'(aOutData), 0);
        checkOutput("rst usage", int'(aUsage), 0);
        checkOutput("rst peak", int'(aPeak), 0);
        checkOutput("rst almost_empty", int'(aAe), 1);
        checkOutput("rst almost_full", int'(aAf), 0);
        afThr = 3'd0;
        #1;
        checkOutput("rst almost_full thr0", int'(aAf), 1);
        afThr = 3'd3;
        resetModels();
        toNegedge();
        #1;
        rst = 1'b0;
        toPosedge();

        $display("[TB] fall-through on DEPTH=5");
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        toNegedge();
        checkOutput("ft out_valid", int'(bOutValid), 1);
        checkOutput("ft out_data", int'(bOutData), 8'hA5);
        toPosedge();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        toNegedge();
        checkOutput("ft usage after pass", int'(bUsage), 0);
        checkOutput("ft peak after pass", int'(bPeak), 0);
        toPosedge();
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        toNegedge();
        checkOutput("ft usage stored", int'(bUsage), 1);
        checkOutput("ft stored data", int'(bOutData), 8'hA5);
        toPosedge();

        $display("[TB] non-power-of-two wrap on DEPTH=5");
        doReset();
        for (int k = 0; k < 22; k++) begin
            applyStimulus(1'b0, (k < 20), 8'(k), (k >= 2), 1'b0);
            toNegedge();
            if (k >= 2) begin
                checkOutput($sformatf("wrap%0d data", k), int'(bOutData), k - 2);
                if (k < 20) checkOutput($sformatf("wrap%0d usage", k), int'(bUsage), 2);
            end
            toPosedge();
        end

        $display("[TB] flush and watermark on DEPTH=4");
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        toNegedge();
        checkOutput("flush usage", int'(aUsage), 0);
        checkOutput("flush out_valid", int'(aOutValid), 0);
        checkOutput("flush peak", int'(aPeak), 3);
        toPosedge();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        toNegedge();
        checkOutput("clear peak", int'(aPeak), 0);
        toPosedge();

        $display("[TB] randomized traffic against the model");
        for (int c = 0; c < 3000; c++) begin
            int bias;
            bias = (c / 300) % 3;
            if (c % 50 == 0) begin
                afThr = 3'($urandom_range(0, 7));
                aeThr = 3'($urandom_range(0, 7));
            end
            applyStimulus(($urandom_range(0, 60) == 0),
                          (bias == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          8'($urandom),
                          (bias == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 40) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
